// File: rtl/memory_requester.sv
// Single-outstanding memory access requester: latches one CPU request, drives the memory
// command until the memory answers or a timeout expires, then inserts one idle GAP cycle.
module memory_requester #(
  parameter int unsigned ramWidth      = 8,
  parameter int unsigned addrSize      = 8,
  parameter int unsigned timeoutCycles = 64
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_indirect,
  input  logic [addrSize-1:0] req_addr,
  input  logic [ramWidth-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [ramWidth-1:0] rsp_data,
  output logic                rsp_err,
  output logic [1:0]          mem_cntrl,
  output logic [addrSize-1:0] mem_addr,
  output logic [ramWidth-1:0] mem_dataIn,
  output logic                mem_isIndirect,
  input  logic [ramWidth-1:0] mem_dataOut,
  input  logic                mem_dataReady
);

  localparam logic [7:0] TimeoutMax  = 8'(timeoutCycles);
  localparam logic [7:0] TimeoutLast = 8'(timeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  write_q, indirect_q;
  logic [addrSize-1:0]   addr_q;
  logic [ramWidth-1:0]   wdata_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ramWidth-1:0]   rsp_data_q, rsp_data_d;
  logic                  latch_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    latch_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          latch_en = 1'b1;
          cnt_d    = 8'd0;
          state_d  = StReq;
        end
      end
      StReq: begin
        cnt_d = (cnt_q < TimeoutMax) ? cnt_q + 8'd1 : cnt_q;
        // Ready in the first REQ cycle may be left over from the previous access.
        if (cnt_q >= 8'd1 && mem_dataReady) begin
          rsp_valid_d = 1'b1;
          if (!write_q) rsp_data_d = mem_dataOut;
          state_d = StGap;
        end else if (cnt_q == TimeoutLast) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      indirect_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      if (latch_en) begin
        write_q    <= req_write;
        indirect_q <= req_indirect;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign mem_cntrl      = (state_q == StReq) ? (write_q ? 2'b10 : 2'b01) : 2'b00;
  assign mem_addr       = addr_q;
  assign mem_dataIn     = wdata_q;
  assign mem_isIndirect = indirect_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_memory_requester.sv
// Directed bench for memory_requester: load, store, stale ready, timeout, mid-access reset
// and back-to-back requests, with inputs driven and outputs sampled on the falling edge.
module tb_memory_requester;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic       req_indirect = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [1:0] mem_cntrl;
  logic [7:0] mem_addr;
  logic [7:0] mem_dataIn;
  logic       mem_isIndirect;
  logic [7:0] mem_dataOut = 8'h00;
  logic       mem_dataReady = 1'b0;

  int errors = 0;
  int checks = 0;

  memory_requester #(
    .ramWidth     (8),
    .addrSize     (8),
    .timeoutCycles(4)
  ) dut (
    .clk           (clk),
    .clrn          (clrn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_indirect  (req_indirect),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .mem_cntrl     (mem_cntrl),
    .mem_addr      (mem_addr),
    .mem_dataIn    (mem_dataIn),
    .mem_isIndirect(mem_isIndirect),
    .mem_dataOut   (mem_dataOut),
    .mem_dataReady (mem_dataReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request for a single edge; returns at the falling edge of the first REQ cycle.
  task automatic start_req(input logic wr, input logic ind, input logic [7:0] a,
                           input logic [7:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_indirect = ind;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_data", rsp_data, 0);
    check("rst_cntrl", mem_cntrl, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_dataIn, 0);
    check("rst_ind", mem_isIndirect, 0);
    clrn = 1'b1;

    // Load, ready in the third REQ cycle
    start_req(1'b0, 1'b0, 8'h3C, 8'h00);
    check("ld_c1", mem_cntrl, 2'b01);
    check("ld_addr", mem_addr, 8'h3C);
    check("ld_busy", req_ready, 0);
    @(negedge clk);
    check("ld_c2", mem_cntrl, 2'b01);
    @(negedge clk);
    check("ld_c3", mem_cntrl, 2'b01);
    check("ld_novld", rsp_valid, 0);
    mem_dataReady = 1'b1;
    mem_dataOut   = 8'hA5;
    @(negedge clk);
    mem_dataReady = 1'b0;
    check("ld_vld", rsp_valid, 1);
    check("ld_err", rsp_err, 0);
    check("ld_data", rsp_data, 8'hA5);
    check("ld_gap", mem_cntrl, 2'b00);
    check("ld_gap_rdy", req_ready, 0);
    @(negedge clk);
    check("ld_idle_vld", rsp_valid, 0);
    check("ld_idle_rdy", req_ready, 1);

    // Store keeps rsp_data untouched
    start_req(1'b1, 1'b1, 8'h10, 8'h5A);
    check("st_cntrl", mem_cntrl, 2'b10);
    check("st_din", mem_dataIn, 8'h5A);
    check("st_ind", mem_isIndirect, 1);
    check("st_addr", mem_addr, 8'h10);
    @(negedge clk);
    check("st_c2", mem_cntrl, 2'b10);
    mem_dataReady = 1'b1;
    mem_dataOut   = 8'hFF;
    @(negedge clk);
    mem_dataReady = 1'b0;
    check("st_vld", rsp_valid, 1);
    check("st_err", rsp_err, 0);
    check("st_data", rsp_data, 8'hA5);
    check("st_hold_din", mem_dataIn, 8'h5A);
    @(negedge clk);

    // Stale ready held from IDLE through the first REQ cycle
    mem_dataReady = 1'b1;
    mem_dataOut   = 8'h77;
    start_req(1'b0, 1'b0, 8'h20, 8'h00);
    check("stale_c1", mem_cntrl, 2'b01);
    @(negedge clk);
    check("stale_c2", mem_cntrl, 2'b01);
    check("stale_novld", rsp_valid, 0);
    @(negedge clk);
    mem_dataReady = 1'b0;
    check("stale_vld", rsp_valid, 1);
    check("stale_data", rsp_data, 8'h77);
    @(negedge clk);

    // Timeout with ready never asserted
    start_req(1'b0, 1'b0, 8'h44, 8'h00);
    n = 0;
    while (mem_cntrl != 2'b00 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("to_cycles", n, 4);
    check("to_vld", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_data", rsp_data, 8'h77);
    @(negedge clk);
    check("to_idle_rdy", req_ready, 1);
    check("to_idle_vld", rsp_valid, 0);
    check("to_idle_err", rsp_err, 0);

    // Reset in the second REQ cycle
    start_req(1'b0, 1'b0, 8'h55, 8'h00);
    @(negedge clk);
    check("ra_c2", mem_cntrl, 2'b01);
    #2 clrn = 1'b0;
    #1;
    check("ra_cntrl", mem_cntrl, 2'b00);
    check("ra_addr", mem_addr, 0);
    check("ra_data", rsp_data, 0);
    check("ra_rdy", req_ready, 1);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    check("ra_novld", rsp_valid, 0);
    start_req(1'b0, 1'b0, 8'h66, 8'h00);
    check("ra_new_c", mem_cntrl, 2'b01);
    check("ra_new_addr", mem_addr, 8'h66);
    mem_dataReady = 1'b1;
    mem_dataOut   = 8'h99;
    @(negedge clk);
    @(negedge clk);
    mem_dataReady = 1'b0;
    check("ra_new_vld", rsp_valid, 1);
    check("ra_new_data", rsp_data, 8'h99);
    @(negedge clk);

    // Back-to-back with req_valid held high
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h01;
    @(negedge clk);
    check("bb_a1", mem_addr, 8'h01);
    req_addr      = 8'h02;
    mem_dataReady = 1'b1;
    mem_dataOut   = 8'h11;
    @(negedge clk);
    check("bb_a1_hold", mem_addr, 8'h01);
    check("bb_c2", mem_cntrl, 2'b01);
    @(negedge clk);
    mem_dataReady = 1'b0;
    check("bb_gap_c", mem_cntrl, 2'b00);
    check("bb_gap_vld", rsp_valid, 1);
    check("bb_gap_data", rsp_data, 8'h11);
    check("bb_gap_rdy", req_ready, 0);
    @(negedge clk);
    check("bb_idle_c", mem_cntrl, 2'b00);
    check("bb_idle_rdy", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bb_a2", mem_addr, 8'h02);
    check("bb_a2_c", mem_cntrl, 2'b01);
    mem_dataReady = 1'b1;
    mem_dataOut   = 8'h22;
    @(negedge clk);
    @(negedge clk);
    mem_dataReady = 1'b0;
    check("bb_a2_vld", rsp_valid, 1);
    check("bb_a2_data", rsp_data, 8'h22);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_requester.md
MEMORY_REQUESTER -- requirements
Module: memory_requester

Interface
REQ-001 Parameter ramWidth, default 8: data word width in bits.
REQ-002 Parameter addrSize, default 8: memory address width in bits.
REQ-003 Parameter timeoutCycles, default 64: the maximum number of cycles in REQ before the access is aborted; legal range 2..255.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 clrn  in  1: asynchronous, active-low reset.
REQ-006 req_valid  in  1: CPU access request.
REQ-007 req_ready  out  1: requester can accept a request this cycle.
REQ-008 req_write  in  1: 1 = store, 0 = load.
REQ-009 req_indirect  in  1: indirect access flag, forwarded to memory.
REQ-010 req_addr  in  addrSize: access address.
REQ-011 req_wdata  in  ramWidth: store data.
REQ-012 rsp_valid  out  1: one-cycle completion pulse.
REQ-013 rsp_data  out  ramWidth: load result, held until the next load completes.
REQ-014 rsp_err  out  1: timeout flag, valid only when rsp_valid=1.
REQ-015 mem_cntrl  out  2: memory command, encoded 00 = idle, 01 = read, 10 = write; 11 is never driven.
REQ-016 mem_addr  out  addrSize: memory address.
REQ-017 mem_dataIn  out  ramWidth: memory write data.
REQ-018 mem_isIndirect  out  1: memory indirect flag.
REQ-019 mem_dataOut  in  ramWidth: memory read data.
REQ-020 mem_dataReady  in  1: memory completion indication.

Function
REQ-021 The FSM SHALL have three states: IDLE, REQ and GAP.
REQ-022 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 In IDLE with req_valid=1, the block SHALL latch req_write, req_indirect, req_addr and req_wdata, clear the cycle counter, and enter REQ on the next edge.
REQ-024 In REQ, mem_cntrl SHALL be 10 if the latched write flag is set, otherwise 01; mem_addr, mem_dataIn and mem_isIndirect SHALL come from the latched values and stay stable for the whole of REQ.
REQ-025 Outside REQ, mem_cntrl SHALL be 00; mem_addr, mem_dataIn and mem_isIndirect SHALL keep their last latched values.
REQ-026 mem_dataReady SHALL be ignored during the first REQ cycle (stale-ready guard), so the minimum access latency is 2 cycles in REQ.
REQ-027 The cycle counter SHALL increment on every REQ cycle, saturating at timeoutCycles.
REQ-028 In REQ with counter >= 1 and mem_dataReady=1, the block SHALL on the next edge:
- pulse rsp_valid=1 with rsp_err=0;
- for a load, load mem_dataOut into rsp_data; for a store, leave rsp_data unchanged;
- enter GAP.
REQ-029 In REQ with counter = timeoutCycles-1 and no qualifying mem_dataReady, the block SHALL on the next edge pulse rsp_valid=1 with rsp_err=1, leave rsp_data unchanged, and enter GAP.
REQ-030 When mem_dataReady qualifies in the same cycle that the timeout is reached, completion SHALL win and rsp_err SHALL be 0.
REQ-031 GAP SHALL last exactly one cycle with mem_cntrl=00, then return to IDLE.
REQ-032 Back-to-back requests SHALL therefore be separated by at least one idle-command cycle.
REQ-033 req_valid SHALL be ignored while req_ready=0.
REQ-034 mem_dataReady SHALL be ignored in IDLE and GAP.
REQ-035 rsp_valid SHALL be 1 for exactly one cycle per accepted request, and rsp_err SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-036 While clrn=0, the block SHALL force:
- state IDLE;
- req_ready=1;
- rsp_valid=0, rsp_err=0;
- rsp_data=0;
- mem_cntrl=00, mem_addr=0, mem_dataIn=0, mem_isIndirect=0;
- cycle counter=0.
REQ-037 Asserting clrn during REQ SHALL abort the access with no rsp_valid pulse; mem_cntrl SHALL become 00 asynchronously.
REQ-038 The first request SHALL be accepted on the first rising edge after clrn deasserts.

Verification
REQ-039 Load: req addr=0x3C, write=0; memory raises ready on the 3rd REQ cycle with dataOut=0xA5 -> mem_cntrl=01 for 3 cycles; rsp_valid pulse; rsp_data=0xA5; rsp_err=0; one GAP cycle with mem_cntrl=00.
REQ-040 Store: write=1, addr=0x10, wdata=0x5A, indirect=1 -> mem_cntrl=10, mem_dataIn=0x5A, mem_isIndirect=1 until ready; rsp_data unchanged.
REQ-041 Stale ready: mem_dataReady held 1 before and during the first REQ cycle -> completion no earlier than the 2nd REQ cycle.
REQ-042 Timeout: timeoutCycles=4, ready never asserted -> exactly 4 REQ cycles, then rsp_valid=1 with rsp_err=1, then GAP, then IDLE.
REQ-043 Reset mid-access: clrn low in the 2nd REQ cycle -> outputs take their reset values immediately, no rsp_valid pulse, and a new request is accepted after release.
REQ-044 Back-to-back: req_valid held 1 for two requests -> the second is accepted only in IDLE after GAP, and mem_cntrl=00 between the two accesses.
